// File: rtl/multilane_parity_checker.sv
// Multi-lane framed parity checker: DATA_BITS data beats, then one parity beat per frame.
// Optional saturating error counter on output err_cnt, enabled by defining PARITY_ERR_CNT_EN.
module multilane_parity_checker #(
  parameter int LANES     = 1,
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 8,
  localparam int IDX_W    = $clog2(DATA_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [LANES-1:0] in_bit,
  input  logic             sof,
  input  logic             odd_mode,
  output logic [LANES-1:0] z,
  output logic             busy,
  output logic [IDX_W-1:0] bit_idx,
  output logic             frame_done,
`ifdef PARITY_ERR_CNT_EN
  output logic [CNT_W-1:0] err_cnt,
`endif
  output logic [LANES-1:0] par_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [LANES-1:0] z_q;
  logic [IDX_W-1:0] idx_q;
  logic [LANES-1:0] par_err_q;
  logic             done_q;
  logic             mode_q;

  // Handshake: a beat is transferred on every rising edge where in_valid is high.
  // There is no back-pressure; the block always accepts. With in_valid low nothing moves.
  logic             start;
  logic             data_beat;
  logic             par_beat;
  logic             last_data;
  logic [IDX_W-1:0] idx_inc;
  logic [LANES-1:0] new_err;

  always_comb begin
    start     = in_valid && sof;
    data_beat = in_valid && !sof && (state_q == S_DATA);
    par_beat  = in_valid && !sof && (state_q == S_CHECK);
    idx_inc   = idx_q + ONE_IDX;
    last_data = data_beat && (idx_inc == LAST_IDX);
    // Odd mode inverts the per-lane comparison.
    new_err   = z_q ^ in_bit ^ {LANES{mode_q}};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; sof in any state restarts the frame.
  always_comb begin
    state_d = state_q;
    if (start) begin
      if (DATA_BITS == 1) begin
        state_d = S_CHECK;
      end else begin
        state_d = S_DATA;
      end
    end else if (last_data) begin
      state_d = S_CHECK;
    end else if (par_beat) begin
      state_d = S_IDLE;
    end
  end

  // Output logic
  always_comb begin
    busy       = (state_q != S_IDLE);
    z          = z_q;
    bit_idx    = idx_q;
    frame_done = done_q;
    par_err    = par_err_q;
  end

  // Frame datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q       <= '0;
      idx_q     <= '0;
      par_err_q <= '0;
      done_q    <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      done_q <= par_beat;
      if (start) begin
        z_q    <= in_bit;
        idx_q  <= ONE_IDX;
        mode_q <= odd_mode;
      end else if (data_beat) begin
        z_q   <= z_q ^ in_bit;
        idx_q <= idx_inc;
      end else if (par_beat) begin
        par_err_q <= new_err;
        z_q       <= '0;
        idx_q     <= '0;
      end
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  // Counts frames with any lane in error; sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (par_beat && (|new_err) && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
